// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle for the data memory controller.
// master drives requests; slave returns load data and status.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] endereco;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              ready;
  logic              access_err;

  modport master (
    output mem_read, mem_write, funct3, endereco, write_data,
    input  read_data, read_valid, ready, access_err
  );

  modport slave (
    input  mem_read, mem_write, funct3, endereco, write_data,
    output read_data, read_valid, ready, access_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed word memory with RV32 load/store sizing,
// post-reset clear sweep and misalign/illegal detection.
module data_memory_ctrl #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter bit INIT_ZERO = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          read_valid_q, read_valid_d;
  logic          ready_q, ready_d;
  logic          access_err_q, access_err_d;

  logic [31:0]   mem [DEPTH];

  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [7:0]    b;
  logic [15:0]   h;

  assign idx     = bus.endereco[IW+1:2];
  assign off     = bus.endereco[1:0];
  assign word    = mem[idx];
  assign shifted = word >> {off, 3'b000};
  assign b       = shifted[7:0];
  assign h       = off[1] ? word[31:16] : word[15:0];

  // Upper address bits wrap away.
  if (ADDR_W > IW + 2) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^bus.endereco[ADDR_W-1:IW+2];
  end

  logic          ld_ok, st_ok;
  logic [31:0]   ld_val;
  logic [3:0]    be;
  logic [31:0]   wdat;

  // Size decode: legality, alignment, load extension, store lanes.
  always_comb begin
    ld_ok  = 1'b0;
    st_ok  = 1'b0;
    ld_val = '0;
    be     = '0;
    wdat   = '0;
    case (bus.funct3)
      3'b000: begin
        ld_ok  = 1'b1;
        st_ok  = 1'b1;
        ld_val = {{24{b[7]}}, b};
        be     = 4'b0001 << off;
        wdat   = {4{bus.write_data[7:0]}};
      end
      3'b001: begin
        ld_ok  = !off[0];
        st_ok  = !off[0];
        ld_val = {{16{h[15]}}, h};
        be     = off[1] ? 4'b1100 : 4'b0011;
        wdat   = {2{bus.write_data[15:0]}};
      end
      3'b010: begin
        ld_ok  = (off == 2'b00);
        st_ok  = (off == 2'b00);
        ld_val = word;
        be     = 4'b1111;
        wdat   = bus.write_data;
      end
      3'b100: begin
        ld_ok  = 1'b1;
        ld_val = {24'd0, b};
      end
      3'b101: begin
        ld_ok  = !off[0];
        ld_val = {16'd0, h};
      end
      default: ;
    endcase
  end

  logic          ld_go, st_go, req_err;
  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wd;

  assign ld_go   = ready_q & bus.mem_read & ld_ok;
  assign st_go   = ready_q & bus.mem_write & st_ok;
  assign req_err = ready_q &
                   ((bus.mem_read & !ld_ok) |
                    (bus.mem_write & !st_ok));

  // Next-state: clear sweep in INIT, request service in RUN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    ready_d      = ready_q;
    access_err_d = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = idx;
    mem_be       = be;
    mem_wd       = wdat;
    if (state_q == INIT) begin
      if (INIT_ZERO) begin
        mem_we  = 1'b1;
        mem_idx = cnt_q;
        mem_be  = 4'b1111;
        mem_wd  = '0;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end else begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end else begin
      read_valid_d = ld_go;
      access_err_d = req_err;
      mem_we       = st_go;
      if (ld_go) read_data_d = ld_val;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      ready_q      <= ready_d;
      access_err_q <= access_err_d;
    end
  end

  // Storage array: byte-lane writes, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.ready      = ready_q;
  assign bus.access_err = access_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: directed
// loads/stores, errors, wrap and reset sweeps.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_W(32)) bus ();

  data_memory_ctrl #(
    .DEPTH(256),
    .ADDR_W(32),
    .INIT_ZERO(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        rv;
    logic        err;
    logic [31:0] d;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic erv,
                     input logic eerr, input logic [31:0] ed);
    exp_t e;
    @(negedge clk);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.funct3     = f3;
    bus.endereco   = a;
    bus.write_data = wd;
    if (erv || eerr) begin
      e.rv  = erv;
      e.err = eerr;
      e.d   = ed;
      sbq.push_back(e);
    end
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] ed);
    req(1'b1, 1'b0, f3, a, 32'h0, 1'b1, 1'b0, ed);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd);
    req(1'b0, 1'b1, f3, a, wd, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string nm);
    int c;
    c = 0;
    while (!bus.ready && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(nm, c, 256);
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_rdata"}, bus.read_data, 32'h0);
    chk({nm, "_rvalid"}, {31'd0, bus.read_valid}, 32'h0);
    chk({nm, "_ready"}, {31'd0, bus.ready}, 32'h0);
    chk({nm, "_err"}, {31'd0, bus.access_err}, 32'h0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.read_valid || bus.access_err)) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got rv=%0b err=%0b data=%h expected none",
                 bus.read_valid, bus.access_err, bus.read_data);
      end else begin
        e = sbq.pop_front();
        chk("resp_valid", {31'd0, bus.read_valid}, {31'd0, e.rv});
        chk("resp_err", {31'd0, bus.access_err}, {31'd0, e.err});
        if (e.rv) chk("resp_data", bus.read_data, e.d);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'b000;
    bus.endereco   = '0;
    bus.write_data = '0;
    #1;
    chk_zero_outs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init_len");

    ld(F_W, 32'h3FC, 32'h0);

    st(F_W, 32'h10, 32'h80F1_7F22);
    ld(F_B, 32'h10, 32'h0000_0022);
    ld(F_B, 32'h13, 32'hFFFF_FF80);
    ld(F_BU, 32'h13, 32'h0000_0080);
    ld(F_H, 32'h12, 32'hFFFF_80F1);
    ld(F_HU, 32'h12, 32'h0000_80F1);
    ld(F_H, 32'h10, 32'h0000_7F22);
    ld(F_B, 32'h11, 32'h0000_007F);

    st(F_W, 32'h10, 32'h1122_3344);
    st(F_B, 32'h11, 32'hFFFF_FFAA);
    ld(F_W, 32'h10, 32'h1122_AA44);
    st(F_H, 32'h12, 32'h1234_BEEF);
    ld(F_W, 32'h10, 32'hBEEF_AA44);

    req(1'b0, 1'b1, F_W, 32'h06, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
    req(1'b1, 1'b0, F_H, 32'h05, 32'h0, 1'b0, 1'b1, 32'h0);
    req(1'b0, 1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    req(1'b0, 1'b1, F_BU, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    req(1'b1, 1'b0, 3'b110, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0);
    idle(1);
    chk("rdata_hold", bus.read_data, 32'hBEEF_AA44);
    ld(F_W, 32'h04, 32'h0);
    ld(F_W, 32'h10, 32'hBEEF_AA44);

    st(F_W, 32'h20, 32'h1);
    req(1'b1, 1'b1, F_W, 32'h20, 32'h2, 1'b1, 1'b0, 32'h1);
    ld(F_W, 32'h20, 32'h2);
    st(F_W, 32'h420, 32'h55AA);
    ld(F_W, 32'h20, 32'h55AA);
    req(1'b1, 1'b1, 3'b011, 32'h20, 32'h77, 1'b0, 1'b1, 32'h0);
    ld(F_W, 32'h20, 32'h55AA);
    req(1'b1, 1'b1, F_H, 32'h21, 32'h99, 1'b0, 1'b1, 32'h0);
    ld(F_W, 32'h20, 32'h55AA);
    idle(3);

    st(F_W, 32'h30, 32'hCAFE_0001);
    st(F_W, 32'h34, 32'hCAFE_0002);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("rst_store");
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init_restart");
    ld(F_W, 32'h30, 32'h0);
    ld(F_W, 32'h10, 32'h0);
    idle(3);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
